reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
Shares the register file's single write port between two writers. The in-order pipeline writeback stage is the first. The multi-cycle multiply/divide unit (MDU) is the second; its results are buffered in a 2-entry FIFO. The block drives REG_write_1, REG_address_wr and REG_data_wb_in1 of the register file. It stalls the pipeline on lost arbitration and on read-after-write hazards against buffered MDU results.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
STARVE_MAX, 4, consecutive pipeline wins tolerated while the FIFO is non-empty before the FIFO is forced a grant (range 1..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
SYS_reset  in  1  synchronous, active-high reset
PIPE_wb_valid  in  1  pipeline writeback request
PIPE_wb_addr  in  ADDR_W  pipeline destination register
PIPE_wb_data  in  DATA_W  pipeline writeback data
PIPE_stall  out  1  combinational; pipeline request not granted this cycle
MDU_wb_valid  in  1  MDU result valid
MDU_wb_addr  in  ADDR_W  MDU destination register
MDU_wb_data  in  DATA_W  MDU result
MDU_wb_ready  out  1  combinational; FIFO can accept
REG_address1  in  ADDR_W  decode-stage read address 1
REG_address2  in  ADDR_W  decode-stage read address 2
hazard_stall  out  1  combinational; a decode read hits a queued MDU write
REG_write_1  out  1  registered write enable to the register file
REG_address_wr  out  ADDR_W  registered write address
REG_data_wb_in1  out  DATA_W  registered write data

Behaviour:
- Reset (sync): FIFO emptied (contents discarded), starvation counter = 0, REG_write_1 = 0, REG_address_wr = 0, REG_data_wb_in1 = 0. MDU_wb_ready = 0 while SYS_reset = 1. A reset mid-operation loses queued writes and no queued write is emitted afterwards.
- FIFO: 2 entries of {addr, data}.
  - MDU_wb_ready = !SYS_reset && count < 2. It uses the pre-edge count, so a full FIFO is not ready even in a cycle where it dequeues.
  - Handshake: a transfer occurs at the rising edge when MDU_wb_valid && MDU_wb_ready.
  - A transfer with MDU_wb_addr = 0 is accepted and dropped; it is not enqueued.
  - A new entry becomes eligible for grant in the cycle after its enqueue edge.
- Eligibility:
  - pipe_req = PIPE_wb_valid && PIPE_wb_addr != 0. Writes to r0 are never emitted and never stall.
  - fifo_req = count > 0.
- Arbitration (combinational, every cycle):
  - If fifo_req and counter == STARVE_MAX, grant the FIFO.
  - Otherwise, if pipe_req, grant the pipeline.
  - Otherwise, if fifo_req, grant the FIFO.
  - Otherwise, no grant.
- PIPE_stall = pipe_req && FIFO granted. While stalled, the pipeline holds its WB inputs; the arbiter holds no copy of them.
- Starvation counter:
  - Clears when the FIFO is granted or the FIFO is empty.
  - Increments when fifo_req and the pipeline is granted.
  - Saturates at STARVE_MAX.
- Output stage, at each rising edge:
  - REG_write_1 <= any grant.
  - On a grant, address and data take the winner's values.
  - With no grant, address and data hold their previous values.
  - The register file commits at the following falling edge.
- FIFO dequeue occurs at the edge on which its head is granted. Simultaneous enqueue and dequeue keeps count unchanged.
- Latency:
  - Pipeline request to REG_write_1 high: 1 edge.
  - MDU accept to REG_write_1 high: minimum 2 edges, when the pipeline is idle.
- hazard_stall = 1 when any valid FIFO entry's addr equals REG_address1 or REG_address2, with the compared address nonzero.
  - The entry currently in the output stage is excluded; the register file bypasses it.
  - hazard_stall is independent of PIPE_stall.
- The FIFO preserves MDU order. Two queued writes to the same register commit in arrival order.

Test Plan:
1. Pipe only: PIPE r5 = 0xDEADBEEF for one cycle -> next cycle REG_write_1 = 1, REG_address_wr = 5, REG_data_wb_in1 = 0xDEADBEEF, PIPE_stall = 0 throughout; the following cycle REG_write_1 = 0 with address/data held.
2. r0 suppression: PIPE addr 0 data 0xFFFFFFFF, and MDU addr 0 accepted -> REG_write_1 never asserts, PIPE_stall = 0, FIFO count stays 0.
3. MDU path: pipe idle, MDU r7 = 0x12345678 accepted at edge N -> REG_write_1 = 1, addr 7, data 0x12345678 after edge N+1; hazard_stall = 1 with REG_address1 = 7 between edges N and N+1 only.
4. Starvation (STARVE_MAX = 4): pipe_req every cycle with distinct addresses, one MDU r9 entry queued -> pipeline granted 4 consecutive cycles; in the 5th cycle the FIFO is granted, PIPE_stall = 1 for exactly that cycle, r9 is written next, and the counter returns to 0.
5. Backpressure: pipe busy, MDU offers r10, r11, r12 back-to-back -> r10 and r11 accepted, MDU_wb_ready = 0 and r12 held; hazard_stall = 1 for REG_address2 = 11; r12 is accepted only after the edge that dequeues r10.
6. Reset mid-operation: FIFO holding r10 and r11, assert SYS_reset one cycle -> after that edge REG_write_1 = 0, outputs 0, hazard_stall = 0; MDU_wb_ready = 1 once reset deasserts; neither r10 nor r11 is ever written.

Source files
------------

// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: bundles the pipeline writeback, MDU writeback, decode
// read-address and register-file write signals around reg_wb_arbiter.
//   slave  : the arbiter's view (requests in, grants/stalls/writes out)
//   master : the surrounding core / testbench view
// dbg_fifo_count and dbg_starve_cnt expose internal state for observation.
//
// Handshake: an MDU result transfers on the rising clock edge where
// MDU_wb_valid && MDU_wb_ready are both high. MDU_wb_ready does not depend
// on MDU_wb_valid; the MDU holds its valid/addr/data until the transfer.
interface reg_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              PIPE_wb_valid;
  logic [ADDR_W-1:0] PIPE_wb_addr;
  logic [DATA_W-1:0] PIPE_wb_data;
  logic              PIPE_stall;
  logic              MDU_wb_valid;
  logic [ADDR_W-1:0] MDU_wb_addr;
  logic [DATA_W-1:0] MDU_wb_data;
  logic              MDU_wb_ready;
  logic [ADDR_W-1:0] REG_address1;
  logic [ADDR_W-1:0] REG_address2;
  logic              hazard_stall;
  logic              REG_write_1;
  logic [ADDR_W-1:0] REG_address_wr;
  logic [DATA_W-1:0] REG_data_wb_in1;
  logic [1:0]        dbg_fifo_count;
  logic [3:0]        dbg_starve_cnt;

  modport slave (
    input  PIPE_wb_valid, PIPE_wb_addr, PIPE_wb_data,
    input  MDU_wb_valid, MDU_wb_addr, MDU_wb_data,
    input  REG_address1, REG_address2,
    output PIPE_stall, MDU_wb_ready, hazard_stall,
    output REG_write_1, REG_address_wr, REG_data_wb_in1,
    output dbg_fifo_count, dbg_starve_cnt
  );

  modport master (
    output PIPE_wb_valid, PIPE_wb_addr, PIPE_wb_data,
    output MDU_wb_valid, MDU_wb_addr, MDU_wb_data,
    output REG_address1, REG_address2,
    input  PIPE_stall, MDU_wb_ready, hazard_stall,
    input  REG_write_1, REG_address_wr, REG_data_wb_in1,
    input  dbg_fifo_count, dbg_starve_cnt
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register file's single write port between the
// pipeline writeback stage and the multiply/divide unit. MDU results are
// buffered in a 2-entry FIFO. The pipeline normally wins; after STARVE_MAX
// consecutive pipeline wins with the FIFO non-empty, the FIFO is forced a
// grant. The decode stage is stalled when it reads a register that still
// has a queued MDU write.
// Ports:
//   clk        : clock, all state on the rising edge
//   SYS_reset  : synchronous active-high reset
//   bus        : reg_wb_arbiter_if.slave (pipeline / MDU / decode / regfile)
module reg_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            SYS_reset,
  reg_wb_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // FIFO storage and pointers
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [DATA_W-1:0] fifo_data_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [3:0]        starve_q, starve_d;

  // Output stage
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic mdu_ready, push, pop;
  logic pipe_req, fifo_req;
  logic grant_fifo, grant_pipe;
  logic hazard;

  always_comb begin
    mdu_ready  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    pipe_req   = 1'b0;
    fifo_req   = 1'b0;
    grant_fifo = 1'b0;
    grant_pipe = 1'b0;
    count_d    = count_q;
    starve_d   = starve_q;
    hazard     = 1'b0;

    // Readiness uses the pre-edge count: a full FIFO is never ready, even
    // in a cycle where it dequeues.
    mdu_ready = !SYS_reset && (count_q != 2'd2);
    // r0 writes are accepted from the MDU but never stored.
    push      = bus.MDU_wb_valid && mdu_ready && (bus.MDU_wb_addr != '0);

    pipe_req  = bus.PIPE_wb_valid && (bus.PIPE_wb_addr != '0);
    fifo_req  = (count_q != 2'd0);

    grant_fifo = fifo_req && ((starve_q == STARVE_LIM) || !pipe_req);
    grant_pipe = pipe_req && !grant_fifo;
    pop        = grant_fifo;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (grant_fifo || !fifo_req) begin
      starve_d = 4'd0;
    end else if (grant_pipe && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end

    // A slot is occupied when the FIFO is full, or when it is the head of a
    // single-entry FIFO. A granted entry has already left the FIFO when it
    // sits in the output stage, and the register file bypasses that one.
    for (int i = 0; i < 2; i++) begin
      if ((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)))) begin
        if (((bus.REG_address1 != '0) && (fifo_addr_q[i] == bus.REG_address1)) ||
            ((bus.REG_address2 != '0) && (fifo_addr_q[i] == bus.REG_address2))) begin
          hazard = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      starve_q  <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q  <= count_d;
      starve_q <= starve_d;
      wr_en_q  <= grant_fifo || grant_pipe;
      if (grant_fifo) begin
        wr_addr_q <= fifo_addr_q[rd_ptr_q];
        wr_data_q <= fifo_data_q[rd_ptr_q];
      end else if (grant_pipe) begin
        wr_addr_q <= bus.PIPE_wb_addr;
        wr_data_q <= bus.PIPE_wb_data;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone, and push
  // is already blocked while SYS_reset is high.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.MDU_wb_addr;
      fifo_data_q[wr_ptr_q] <= bus.MDU_wb_data;
    end
  end

  assign bus.PIPE_stall      = pipe_req && grant_fifo;
  assign bus.MDU_wb_ready    = mdu_ready;
  assign bus.hazard_stall    = hazard;
  assign bus.REG_write_1     = wr_en_q;
  assign bus.REG_address_wr  = wr_addr_q;
  assign bus.REG_data_wb_in1 = wr_data_q;
  assign bus.dbg_fifo_count  = count_q;
  assign bus.dbg_starve_cnt  = starve_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int WB_W   = ADDR_W + DATA_W;

  logic clk;
  logic SYS_reset;

  reg_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .SYS_reset (SYS_reset),
    .bus       (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected register-file writes {addr, data}, in commit order
  logic [WB_W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Advance one edge, then compare any write emitted by the DUT against
  // the head of the expected queue.
  task automatic step();
    logic [WB_W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("spurious_write", 64'(bus.REG_write_1), 64'd0);
    end else if (bus.REG_write_1 === 1'b1) begin
      e = exp_q.pop_front();
      chk("wb_addr_data", 64'({bus.REG_address_wr, bus.REG_data_wb_in1}), 64'(e));
    end
  endtask

  task automatic drive_pipe(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.PIPE_wb_valid = v;
    bus.PIPE_wb_addr  = a;
    bus.PIPE_wb_data  = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.MDU_wb_valid = v;
    bus.MDU_wb_addr  = a;
    bus.MDU_wb_data  = d;
  endtask

  initial begin
    SYS_reset = 1'b1;
    drive_pipe(1'b0, '0, '0);
    drive_mdu(1'b0, '0, '0);
    bus.REG_address1 = '0;
    bus.REG_address2 = '0;

    // Reset state
    step();
    step();
    chk("rst_write",  64'(bus.REG_write_1), 64'd0);
    chk("rst_addr",   64'(bus.REG_address_wr), 64'd0);
    chk("rst_data",   64'(bus.REG_data_wb_in1), 64'd0);
    chk("rst_ready",  64'(bus.MDU_wb_ready), 64'd0);
    chk("rst_count",  64'(bus.dbg_fifo_count), 64'd0);
    chk("rst_starve", 64'(bus.dbg_starve_cnt), 64'd0);
    SYS_reset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.MDU_wb_ready), 64'd1);

    // 1: pipeline-only write
    drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    #1 chk("t1_stall_req", 64'(bus.PIPE_stall), 64'd0);
    step();
    drive_pipe(1'b0, '0, '0);
    #1;
    chk("t1_write", 64'(bus.REG_write_1), 64'd1);
    chk("t1_stall_after", 64'(bus.PIPE_stall), 64'd0);
    step();
    chk("t1_write_drop", 64'(bus.REG_write_1), 64'd0);
    chk("t1_addr_hold", 64'(bus.REG_address_wr), 64'd5);
    chk("t1_data_hold", 64'(bus.REG_data_wb_in1), 64'hDEADBEEF);

    // 2: r0 suppression on both paths
    drive_pipe(1'b1, 5'd0, 32'hFFFFFFFF);
    drive_mdu(1'b1, 5'd0, 32'h55555555);
    #1;
    chk("t2_stall", 64'(bus.PIPE_stall), 64'd0);
    chk("t2_ready", 64'(bus.MDU_wb_ready), 64'd1);
    step();
    drive_pipe(1'b0, '0, '0);
    drive_mdu(1'b0, '0, '0);
    #1;
    chk("t2_count", 64'(bus.dbg_fifo_count), 64'd0);
    chk("t2_write", 64'(bus.REG_write_1), 64'd0);
    step();
    chk("t2_write_late", 64'(bus.REG_write_1), 64'd0);

    // 3: MDU path with idle pipeline, hazard window
    drive_mdu(1'b1, 5'd7, 32'h12345678);
    bus.REG_address1 = 5'd7;
    expect_wr(5'd7, 32'h12345678);
    #1;
    chk("t3_hazard_pre", 64'(bus.hazard_stall), 64'd0);
    step();
    drive_mdu(1'b0, '0, '0);
    #1;
    chk("t3_hazard_queued", 64'(bus.hazard_stall), 64'd1);
    chk("t3_write_early", 64'(bus.REG_write_1), 64'd0);
    chk("t3_count1", 64'(bus.dbg_fifo_count), 64'd1);
    step();
    chk("t3_write", 64'(bus.REG_write_1), 64'd1);
    chk("t3_hazard_clear", 64'(bus.hazard_stall), 64'd0);
    chk("t3_count0", 64'(bus.dbg_fifo_count), 64'd0);
    bus.REG_address1 = '0;

    // 4: starvation limit forces the FIFO after 4 pipeline wins
    drive_mdu(1'b1, 5'd9, 32'h99999999);
    step();
    drive_mdu(1'b0, '0, '0);
    chk("t4_count", 64'(bus.dbg_fifo_count), 64'd1);
    chk("t4_starve0", 64'(bus.dbg_starve_cnt), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      drive_pipe(1'b1, 5'(i), 32'hA0000000 + 32'(i));
      expect_wr(5'(i), 32'hA0000000 + 32'(i));
      #1 chk("t4_pipe_stall", 64'(bus.PIPE_stall), 64'd0);
      step();
      chk("t4_starve_inc", 64'(bus.dbg_starve_cnt), 64'(i));
    end
    drive_pipe(1'b1, 5'd5, 32'hA0000005);
    expect_wr(5'd9, 32'h99999999);
    expect_wr(5'd5, 32'hA0000005);
    #1 chk("t4_forced_stall", 64'(bus.PIPE_stall), 64'd1);
    step();
    chk("t4_starve_clr", 64'(bus.dbg_starve_cnt), 64'd0);
    chk("t4_count_drain", 64'(bus.dbg_fifo_count), 64'd0);
    #1 chk("t4_stall_release", 64'(bus.PIPE_stall), 64'd0);
    step();
    drive_pipe(1'b0, '0, '0);
    step();

    // 5: backpressure on a full FIFO
    drive_pipe(1'b1, 5'd20, 32'hC0000020);
    drive_mdu(1'b1, 5'd10, 32'hB0000010);
    expect_wr(5'd20, 32'hC0000020);
    #1 chk("t5_ready_r10", 64'(bus.MDU_wb_ready), 64'd1);
    step();
    drive_pipe(1'b1, 5'd21, 32'hC0000021);
    drive_mdu(1'b1, 5'd11, 32'hB0000011);
    expect_wr(5'd21, 32'hC0000021);
    #1 chk("t5_ready_r11", 64'(bus.MDU_wb_ready), 64'd1);
    step();
    drive_pipe(1'b0, '0, '0);
    drive_mdu(1'b1, 5'd12, 32'hB0000012);
    bus.REG_address2 = 5'd11;
    expect_wr(5'd10, 32'hB0000010);
    #1;
    chk("t5_full_not_ready", 64'(bus.MDU_wb_ready), 64'd0);
    chk("t5_hazard_r11", 64'(bus.hazard_stall), 64'd1);
    chk("t5_count_full", 64'(bus.dbg_fifo_count), 64'd2);
    step();
    chk("t5_count_after_deq", 64'(bus.dbg_fifo_count), 64'd1);
    expect_wr(5'd11, 32'hB0000011);
    #1;
    chk("t5_ready_r12", 64'(bus.MDU_wb_ready), 64'd1);
    chk("t5_hazard_r11_still", 64'(bus.hazard_stall), 64'd1);
    step();
    drive_mdu(1'b0, '0, '0);
    chk("t5_count_swap", 64'(bus.dbg_fifo_count), 64'd1);
    expect_wr(5'd12, 32'hB0000012);
    #1 chk("t5_hazard_gone", 64'(bus.hazard_stall), 64'd0);
    step();
    chk("t5_count_empty", 64'(bus.dbg_fifo_count), 64'd0);
    bus.REG_address2 = '0;
    step();

    // 6: reset mid-operation discards queued MDU writes
    drive_pipe(1'b1, 5'd1, 32'hD0000001);
    drive_mdu(1'b1, 5'd10, 32'hE0000010);
    expect_wr(5'd1, 32'hD0000001);
    step();
    drive_pipe(1'b1, 5'd2, 32'hD0000002);
    drive_mdu(1'b1, 5'd11, 32'hE0000011);
    expect_wr(5'd2, 32'hD0000002);
    step();
    drive_mdu(1'b0, '0, '0);
    drive_pipe(1'b1, 5'd3, 32'hD0000003);
    bus.REG_address1 = 5'd10;
    SYS_reset = 1'b1;
    #1;
    chk("t6_hazard_pre", 64'(bus.hazard_stall), 64'd1);
    chk("t6_count_pre", 64'(bus.dbg_fifo_count), 64'd2);
    chk("t6_ready_in_rst", 64'(bus.MDU_wb_ready), 64'd0);
    step();
    chk("t6_write", 64'(bus.REG_write_1), 64'd0);
    chk("t6_addr", 64'(bus.REG_address_wr), 64'd0);
    chk("t6_data", 64'(bus.REG_data_wb_in1), 64'd0);
    chk("t6_hazard", 64'(bus.hazard_stall), 64'd0);
    chk("t6_count", 64'(bus.dbg_fifo_count), 64'd0);
    SYS_reset = 1'b0;
    drive_pipe(1'b0, '0, '0);
    #1 chk("t6_ready_post", 64'(bus.MDU_wb_ready), 64'd1);
    for (int i = 0; i < 4; i++) step();
    bus.REG_address1 = '0;

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
